// File: rtl/ps2_pkg.sv
// PS/2 keyboard controller shared definitions.
// Scan prefixes, FSM state encodings and the event bundle.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int         EVT_W   = 10;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frame_state_e;

  typedef enum logic [1:0] {
    D_BASE,
    D_EXT,
    D_BRK,
    D_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with valid/ready pop side.
// Head entry reads as zero while empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  ps2_event_t data_i,
  input  logic       ready_i,
  output ps2_event_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ps2_event_t    mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = ready_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Pointer and occupancy next state; pointers wrap naturally.
  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard frame receiver, prefix decoder and event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_100Mhz,
  input  logic       reset_n,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic fall, bit_in, par_good, timeout;

  frame_state_e  fst_q, fst_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  dec_state_e    dst_q, dst_d;
  logic          push_q, push_d;
  ps2_event_t    evt_q, evt_d;
  logic          ovf_q, ovf_d;

  ps2_event_t    head;
  logic          full, empty;

  assign fall   = clk_s3_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

`ifdef PS2_PARITY_CHECK_EN
  assign par_good = ^{shift_q, par_q};
`else
  // Parity is captured but never gates the frame.
  assign par_good = 1'b1 | par_q;
`endif

  assign timeout = (fst_q != F_IDLE) && !fall &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // All controller state; synchronizers idle high.
  always_ff @(posedge clk_100Mhz) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      fst_q    <= F_IDLE;
      bcnt_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      dst_q    <= D_BASE;
      push_q   <= 1'b0;
      evt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      clk_s1_q <= PS2Clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= PS2Data;
      dat_s2_q <= dat_s1_q;
      fst_q    <= fst_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      dst_q    <= dst_d;
      push_q   <= push_d;
      evt_q    <= evt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Frame FSM next state: one step per falling edge.
  always_comb begin
    fst_d = fst_q;
    if (timeout) begin
      fst_d = F_IDLE;
    end else if (fall) begin
      unique case (fst_q)
        F_IDLE:   fst_d = bit_in ? F_IDLE : F_DATA;
        F_DATA:   fst_d = (bcnt_q == 3'd7) ? F_PARITY : F_DATA;
        F_PARITY: fst_d = F_STOP;
        F_STOP:   fst_d = F_IDLE;
        default:  fst_d = F_IDLE;
      endcase
    end
  end

  // Frame datapath: shift, parity, timeout and completion.
  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    tmo_d   = (fall || fst_q == F_IDLE) ? '0 : tmo_q + 1'b1;
    if (timeout) begin
      tmo_d  = '0;
      ferr_d = 1'b1;
    end else if (fall) begin
      unique case (fst_q)
        F_IDLE:   bcnt_d = '0;
        F_DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
        end
        F_PARITY: par_d = bit_in;
        F_STOP: begin
          done_d = bit_in & par_good;
          ferr_d = ~(bit_in & par_good);
        end
        default: ;
      endcase
    end
  end

  // Decoder next state: prefixes accumulate, errors flush.
  always_comb begin
    dst_d = dst_q;
    if (ferr_q) begin
      dst_d = D_BASE;
    end else if (done_q) begin
      unique case (dst_q)
        D_BASE: begin
          if (shift_q == PS2_EXT)      dst_d = D_EXT;
          else if (shift_q == PS2_BRK) dst_d = D_BRK;
        end
        D_EXT:
          dst_d = (shift_q == PS2_BRK) ? D_EXT_BRK : D_BASE;
        default: dst_d = D_BASE;
      endcase
    end
  end

  // Decoder output: build the event for non-prefix bytes.
  always_comb begin
    push_d = 1'b0;
    evt_d  = '0;
    if (done_q && !ferr_q) begin
      evt_d.code = shift_q;
      unique case (dst_q)
        D_BASE:
          push_d = (shift_q != PS2_EXT) && (shift_q != PS2_BRK);
        D_EXT: begin
          push_d    = (shift_q != PS2_BRK);
          evt_d.ext = 1'b1;
        end
        D_BRK: begin
          push_d    = 1'b1;
          evt_d.brk = 1'b1;
        end
        default: begin
          push_d    = 1'b1;
          evt_d.ext = 1'b1;
          evt_d.brk = 1'b1;
        end
      endcase
    end
  end

  // Overflow sticks once a push is refused.
  always_comb begin
    ovf_d = ovf_q | (push_q & full & ~(key_valid & key_ready));
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_100Mhz),
    .rst_ni  (reset_n),
    .push_i  (push_q),
    .data_i  (evt_q),
    .ready_i (key_ready),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign key_valid = ~empty;
  assign key_code  = head.code;
  assign key_ext   = head.ext;
  assign key_break = head.brk;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller.
// Honours PS2_PARITY_CHECK_EN when choosing bad-parity expectations.
module tb_ps2_key_controller;

  localparam int TMO = 500;
  localparam int H   = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid;
  logic       key_ready = 1'b0;
  logic       frame_err, overflow;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [9:0] ev_q[$];

  always #5 clk = ~clk;

  ps2_key_controller #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_100Mhz (clk),
    .reset_n    (reset_n),
    .PS2Clk     (PS2Clk),
    .PS2Data    (PS2Data),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always @(posedge clk) begin
    if (key_valid && key_ready)
      ev_q.push_back({key_ext, key_break, key_code});
    if (frame_err) err_cnt++;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk) PS2Data = b;
    repeat (H) @(negedge clk);
    PS2Clk = 1'b0;
    repeat (H) @(negedge clk);
    PS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit good_par,
                            input bit pop_at_push);
    logic p;
    p = good_par ? ~^b : ^b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    @(negedge clk) PS2Data = 1'b1;
    repeat (H) @(negedge clk);
    PS2Clk = 1'b0;
    repeat (4) @(negedge clk);
    if (pop_at_push) key_ready = 1'b1;
    @(negedge clk);
    if (pop_at_push) key_ready = 1'b0;
    repeat (H - 5) @(negedge clk);
    PS2Clk = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_valid, frame_err, overflow, key_code} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=0",
               {key_valid, frame_err, overflow, key_code});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({key_valid, frame_err, overflow, key_code} !== 11'd0) begin
      errors++;
      $display("FAIL reset_first got=%h want=0",
               {key_valid, frame_err, overflow, key_code});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    logic [7:0] b;
    int e0;
    b = 8'h1C;
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(1'b0);
    @(negedge clk) PS2Data = 1'b1;
    repeat (H) @(negedge clk);
    PS2Clk = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early valid=%b want=0", key_valid);
    end
    @(negedge clk);
    checks++;
    if ({key_valid, key_ext, key_break, key_code} !== 11'h41C) begin
      errors++;
      $display("FAIL lat_event got=%h want=41c",
               {key_valid, key_ext, key_break, key_code});
    end
    repeat (3) @(negedge clk);
    PS2Clk = 1'b1;
    repeat (4) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_valid, key_code} !== 9'd0 || err_cnt != e0) begin
      errors++;
      $display("FAIL single_pop valid=%b code=%h errs=%0d want 0,00,0",
               key_valid, key_code, err_cnt - e0);
    end
    ev_q.delete();
  endtask

  task automatic test_prefixes;
    key_ready = 1'b1;
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (ev_q.size() != 3) begin
      errors++;
      $display("FAIL prefix_count got=%0d want=3", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0] !== 10'h21C) begin
        errors++;
        $display("FAIL prefix_ext got=%h want=21c", ev_q[0]);
      end
      checks++;
      if (ev_q[1] !== 10'h11C) begin
        errors++;
        $display("FAIL prefix_brk got=%h want=11c", ev_q[1]);
      end
      checks++;
      if (ev_q[2] !== 10'h05A) begin
        errors++;
        $display("FAIL prefix_plain got=%h want=05a", ev_q[2]);
      end
    end
    ev_q.delete();
    key_ready = 1'b0;
  endtask

  task automatic test_ext_break;
    key_ready = 1'b1;
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (ev_q.size() != 1 || ev_q[0] !== 10'h375) begin
      errors++;
      $display("FAIL ext_break n=%0d first=%h want n=1 375",
               ev_q.size(), ev_q.size() ? ev_q[0] : 10'h0);
    end
    ev_q.delete();
    key_ready = 1'b0;
  endtask

  task automatic test_parity;
    int e0;
    e0 = err_cnt;
    key_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
    checks++;
    if (err_cnt != e0 + 1 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL bad_parity errs=%0d events=%0d want 1,0",
               err_cnt - e0, ev_q.size());
    end
`else
    checks++;
    if (err_cnt != e0 || ev_q.size() != 1 ||
        ev_q[0] !== 10'h01C) begin
      errors++;
      $display("FAIL bad_parity errs=%0d events=%0d want 0,1 01c",
               err_cnt - e0, ev_q.size());
    end
`endif
    ev_q.delete();
    key_ready = 1'b0;
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++)
      send_frame(8'h21 + 8'(i), 1'b1, 1'b0);
    send_frame(8'h25, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || ev_q.size() != 1) begin
      errors++;
      $display("FAIL full_pushpop ovf=%b pops=%0d want 0,1",
               overflow, ev_q.size());
    end
    key_ready = 1'b1;
    repeat (8) @(negedge clk);
    key_ready = 1'b0;
    checks++;
    if (ev_q.size() != 5) begin
      errors++;
      $display("FAIL full_drain n=%0d want=5", ev_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp = 8'h21 + 8'(i);
        checks++;
        if (ev_q[i] !== {2'b00, exp}) begin
          errors++;
          $display("FAIL full_order[%0d] got=%h want=%h",
                   i, ev_q[i], exp);
        end
      end
    end
    ev_q.delete();
  endtask

  task automatic test_overflow;
    logic [7:0] exp;
    for (int i = 0; i < 5; i++)
      send_frame(8'h15 + 8'(i), 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow ovf=%b valid=%b want 1,1",
               overflow, key_valid);
    end
    key_ready = 1'b1;
    repeat (8) @(negedge clk);
    key_ready = 1'b0;
    checks++;
    if (ev_q.size() != 4) begin
      errors++;
      $display("FAIL ovf_count got=%0d want=4", ev_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = 8'h15 + 8'(i);
        checks++;
        if (ev_q[i] !== {2'b00, exp}) begin
          errors++;
          $display("FAIL ovf_order[%0d] got=%h want=%h",
                   i, ev_q[i], exp);
        end
      end
    end
    checks++;
    if ({key_valid, key_ext, key_break, key_code} !== 11'd0) begin
      errors++;
      $display("FAIL empty_zero got=%h want=0",
               {key_valid, key_ext, key_break, key_code});
    end
    ev_q.delete();
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TMO - 2 * H - 20) @(negedge clk);
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL tmo_early errs=%0d want=0", err_cnt - e0);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (err_cnt != e0 + 1) begin
      errors++;
      $display("FAIL tmo_pulse errs=%0d want=1", err_cnt - e0);
    end
    key_ready = 1'b1;
    send_frame(8'h29, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (ev_q.size() != 1 || ev_q[0] !== 10'h029 ||
        err_cnt != e0 + 1) begin
      errors++;
      $display("FAIL tmo_recover n=%0d errs=%0d want 1 029 1",
               ev_q.size(), err_cnt - e0);
    end
    ev_q.delete();
    key_ready = 1'b0;
  endtask

  task automatic test_reset_break;
    key_ready = 1'b1;
    send_frame(8'hF0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear ovf=%b valid=%b want 0,0",
               overflow, key_valid);
    end
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (ev_q.size() != 1 || ev_q[0] !== 10'h01C) begin
      errors++;
      $display("FAIL rst_break n=%0d first=%h want 1 01c",
               ev_q.size(), ev_q.size() ? ev_q[0] : 10'h0);
    end
    ev_q.delete();
    key_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefixes();
    test_ext_break();
    test_parity();
    test_full_push_pop();
    test_overflow();
    test_timeout();
    test_reset_break();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_controller.md
PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: idle-clock limit mid-frame, in clk_100Mhz cycles (1 ms).
REQ-003 clk_100Mhz  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 PS2Clk  in  1  raw keyboard clock, asynchronous.
REQ-006 PS2Data  in  1  raw keyboard data, asynchronous.
REQ-007 key_code  out  8  scan code of the head event.
REQ-008 key_ext  out  1  head event carried the E0 prefix.
REQ-009 key_break  out  1  head event is a release (F0 prefix).
REQ-010 key_valid  out  1  FIFO non-empty; head event presented.
REQ-011 key_ready  in  1  consumer accepts the head event when key_valid is high.
REQ-012 frame_err  out  1  one-cycle pulse per discarded frame.
REQ-013 overflow  out  1  sticky; an event was dropped on a full FIFO.

Function
REQ-014 PS2Clk and PS2Data pass through 2-FF synchronizers; a falling edge is synced-previous=1 and synced-current=0.
REQ-015 Frame FSM states: IDLE, DATA, PARITY, STOP; one transition per detected falling edge.
REQ-016 IDLE: data=0 goes to DATA with bit count 0; data=1 stays in IDLE, no error.
REQ-017 DATA: shift in 8 bits LSB first; after the 8th bit go to PARITY.
REQ-018 PARITY: capture the bit, go to STOP.
REQ-019 STOP: data=1 with parity OK completes the byte; otherwise frame_err pulses and the byte is discarded; return to IDLE either way.
REQ-020 Timeout: outside IDLE, TIMEOUT_CYCLES consecutive cycles without a falling edge force IDLE and pulse frame_err; the counter clears on every edge.
REQ-021 Decoder FSM states: BASE, EXT, BRK, EXT_BRK; consumes completed bytes only.
REQ-022 BASE transitions: E0 goes to EXT; F0 goes to BRK; any other byte emits {ext=0, break=0}.
REQ-023 EXT transitions: F0 goes to EXT_BRK; any other byte emits {ext=1, break=0} and returns to BASE.
REQ-024 BRK: any byte emits {ext=0, break=1} and returns to BASE.
REQ-025 EXT_BRK: any byte emits {ext=1, break=1} and returns to BASE.
REQ-026 Any frame_err returns the decoder to BASE; pending prefixes are lost.
REQ-027 Latency: stop edge detected in cycle N, byte complete in N+1, FIFO push in N+2, key_valid high in N+3 when the FIFO was empty.
REQ-028 Pop occurs when key_valid and key_ready are both high in a cycle; the next entry is presented in the following cycle.
REQ-029 Push on a full FIFO without a pop drops the event and sets overflow.
REQ-030 Simultaneous push and pop on a full FIFO accepts both; occupancy is unchanged and overflow is not set.
REQ-031 Push and pop on an empty FIFO: the push is stored and no pop occurs; key_valid is low that cycle.
REQ-032 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked with log2(FIFO_DEPTH)+1 bits.
REQ-033 key_code, key_ext and key_break are 0 whenever key_valid is 0.

Reset
REQ-034 reset_n=0 at a clock edge puts the frame FSM in IDLE and the decoder in BASE, and clears the bit count, shift register, timeout counter, FIFO pointers and occupancy.
REQ-035 All outputs are 0 during reset and in the first cycle after it; synchronizer flops reset to 1.
REQ-036 Reset mid-frame discards the partial frame; the remaining keyboard bits are parsed as new frames and may cause frame_err.

Configuration
REQ-037 Macro PS2_PARITY_CHECK_EN defined: a frame fails unless data bits plus parity bit have odd total parity.
REQ-038 Macro PS2_PARITY_CHECK_EN undefined: the parity bit is captured and ignored; only the stop bit is checked.

Structure
REQ-039 Package ps2_pkg holds: scan constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0; frame and decoder state enums; event width constant 10; an event typedef {ext, brk, code[7:0]}.
REQ-040 Sub-module ps2_event_fifo (synchronous FIFO, FIFO_DEPTH x 10, valid/ready pop, full/empty flags) holds the event buffer; all other logic stays in ps2_key_controller.

Verification
REQ-041 Frame 0x1C with odd parity -> one event {code=1C, ext=0, break=0}, key_valid high 3 cycles after the stop edge.
REQ-042 Sequence E0, F0, 75 with key_ready=1 -> exactly one event {75, ext=1, break=1}; no events for the prefixes.
REQ-043 Frame 0x1C with bad parity and macro defined -> frame_err pulse and no event; macro undefined -> event {1C,0,0}.
REQ-044 key_ready=0 and 5 make codes 0x15..0x19 with FIFO_DEPTH=4 -> 4 events held and overflow=1; popping yields 15,16,17,18 in order.
REQ-045 PS2Clk held high after 4 data bits for 100000 cycles -> frame_err pulse, FSM in IDLE; the next valid frame 0x29 -> event {29,0,0}.
REQ-046 reset_n=0 for 1 cycle after F0 -> decoder in BASE; next byte 0x1C -> event {1C,0,0}, not a break.
